// File: rtl/hex_disp_sched.sv
// Hex display source scheduler: picks RF or DM word for the 7-segment decoder,
// switching on a debounced button or dwell timer. Optional switch counter: HEXDISP_SWCNT_EN.
module hex_disp_sched #(
  parameter int DEB_CYCLES   = 16,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_sel,
  input  logic        auto_en,
  input  logic        freeze,
  input  logic [31:0] RFOUT,
  input  logic [31:0] DMOUT,
  output logic        QSEL,
  output logic [31:0] RF_HOLD,
  output logic [31:0] DM_HOLD
`ifdef HEXDISP_SWCNT_EN
  ,
  output logic [7:0]  sw_cnt
`endif
);

  typedef enum logic {SHOW_DM = 1'b0, SHOW_RF = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic             sync1_reg, sync2_reg;
  logic             deb_level_reg, deb_prev_reg;
  logic [CNT_W-1:0] deb_cnt_reg, deb_cnt_next;
  logic             deb_level_next;
  logic [CNT_W-1:0] dwell_cnt_reg, dwell_cnt_next;
  logic             tog, expiry, do_switch;

  // Two-flop synchronizer for the asynchronous push-button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= btn_sel;
      sync2_reg <= sync1_reg;
    end
  end

  // Debounce: accept a new level only after DEB_CYCLES stable disagreeing samples
  always_comb begin
    deb_cnt_next   = '0;
    deb_level_next = deb_level_reg;
    if (sync2_reg != deb_level_reg) begin
      if (deb_cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
        deb_level_next = sync2_reg;
      end else begin
        deb_cnt_next = deb_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_reg   <= '0;
      deb_level_reg <= 1'b0;
      deb_prev_reg  <= 1'b0;
    end else begin
      deb_cnt_reg   <= deb_cnt_next;
      deb_level_reg <= deb_level_next;
      deb_prev_reg  <= deb_level_reg;
    end
  end

  assign tog       = deb_level_reg & ~deb_prev_reg;
  assign expiry    = auto_en && (dwell_cnt_reg == CNT_W'(DWELL_CYCLES - 1));
  // A coincident toggle and expiry still yield a single switch
  assign do_switch = tog | expiry;

  always_comb begin
    state_next     = state_reg;
    dwell_cnt_next = dwell_cnt_reg + 1'b1;
    if (do_switch) begin
      state_next = (state_reg == SHOW_DM) ? SHOW_RF : SHOW_DM;
    end
    if (!auto_en || do_switch) begin
      dwell_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= SHOW_DM;
      dwell_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      dwell_cnt_reg <= dwell_cnt_next;
    end
  end

  assign QSEL = (state_reg == SHOW_RF);

  // Both hold registers freeze together so the displayed pair stays coherent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RF_HOLD <= '0;
      DM_HOLD <= '0;
    end else if (!freeze) begin
      RF_HOLD <= RFOUT;
      DM_HOLD <= DMOUT;
    end
  end

`ifdef HEXDISP_SWCNT_EN
  logic [7:0] sw_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_cnt_reg <= '0;
    end else if (do_switch) begin
      sw_cnt_reg <= sw_cnt_reg + 8'd1;
    end
  end

  assign sw_cnt = sw_cnt_reg;
`endif

endmodule

// File: tb/tb_hex_disp_sched.sv
// Directed self-checking bench for hex_disp_sched (DEB_CYCLES=4, DWELL_CYCLES=10, CNT_W=4).
module tb_hex_disp_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_sel;
  logic        auto_en;
  logic        freeze;
  logic [31:0] RFOUT;
  logic [31:0] DMOUT;
  logic        QSEL;
  logic [31:0] RF_HOLD;
  logic [31:0] DM_HOLD;
`ifdef HEXDISP_SWCNT_EN
  logic [7:0]  sw_cnt;
`endif

  int checks = 0;
  int errors = 0;

  hex_disp_sched #(
    .DEB_CYCLES  (4),
    .DWELL_CYCLES(10),
    .CNT_W       (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_sel(btn_sel),
    .auto_en(auto_en),
    .freeze (freeze),
    .RFOUT  (RFOUT),
    .DMOUT  (DMOUT),
    .QSEL   (QSEL),
    .RF_HOLD(RF_HOLD),
    .DM_HOLD(DM_HOLD)
`ifdef HEXDISP_SWCNT_EN
    ,
    .sw_cnt (sw_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s got=0x%08h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int   n;
    logic q0;

    rst = 1'b1; btn_sel = 1'b0; auto_en = 1'b0; freeze = 1'b0;
    RFOUT = 32'hAAAA_0001; DMOUT = 32'hBBBB_0002;
    tick(2);
    chk("reset_qsel", {31'd0, QSEL}, 32'd0);
    chk("reset_rf", RF_HOLD, 32'd0);
    chk("reset_dm", DM_HOLD, 32'd0);
    rst = 1'b0;
    tick(1);
    chk("hold_rf_live", RF_HOLD, 32'hAAAA_0001);

    // Glitch of 3 cycles must be ignored
    btn_sel = 1'b1;
    tick(3);
    btn_sel = 1'b0;
    tick(12);
    chk("glitch_no_switch", {31'd0, QSEL}, 32'd0);

    // Real press: QSEL rises 7 cycles after btn_sel
    btn_sel = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (QSEL && n == 0) n = i;
    end
    chk("press_latency", n, 7);
    chk("press_single_toggle", {31'd0, QSEL}, 32'd1);
    btn_sel = 1'b0;
    tick(10);
    chk("release_no_toggle", {31'd0, QSEL}, 32'd1);

    // Asynchronous reset mid-run with QSEL=1
    rst = 1'b1;
    #1;
    chk("async_rst_qsel", {31'd0, QSEL}, 32'd0);
    chk("async_rst_rf", RF_HOLD, 32'd0);
    chk("async_rst_dm", DM_HOLD, 32'd0);
    tick(1);
    rst = 1'b0;

    // Auto mode: switch every 10 cycles
    auto_en = 1'b1;
    tick(9);
    chk("auto_before_1", {31'd0, QSEL}, 32'd0);
    tick(1);
    chk("auto_switch_1", {31'd0, QSEL}, 32'd1);
    tick(9);
    chk("auto_before_2", {31'd0, QSEL}, 32'd1);
    tick(1);
    chk("auto_switch_2", {31'd0, QSEL}, 32'd0);
    tick(5);
    auto_en = 1'b0;
    tick(20);
    chk("auto_off_hold", {31'd0, QSEL}, 32'd0);
    auto_en = 1'b1;
    tick(9);
    chk("reenable_full_dwell", {31'd0, QSEL}, 32'd0);
    tick(1);
    chk("reenable_switch", {31'd0, QSEL}, 32'd1);
    auto_en = 1'b0;
    tick(1);

    // Freeze behaviour
    RFOUT = 32'h1234_5678; DMOUT = 32'hDEAD_BEEF;
    tick(1);
    chk("hold_rf_load", RF_HOLD, 32'h1234_5678);
    chk("hold_dm_load", DM_HOLD, 32'hDEAD_BEEF);
    freeze = 1'b1;
    RFOUT = 32'h0BAD_F00D; DMOUT = 32'hCAFE_0000;
    tick(3);
    chk("frozen_rf", RF_HOLD, 32'h1234_5678);
    chk("frozen_dm", DM_HOLD, 32'hDEAD_BEEF);
    freeze = 1'b0;
    tick(1);
    chk("unfrozen_rf", RF_HOLD, 32'h0BAD_F00D);
    chk("unfrozen_dm", DM_HOLD, 32'hCAFE_0000);

    // Collision: button press timed so tog lands on the dwell expiry cycle
    q0 = QSEL;
    auto_en = 1'b1;
    tick(3);
    btn_sel = 1'b1;
    tick(7);
    chk("collision_single", {31'd0, QSEL}, {31'd0, ~q0});
    tick(9);
    chk("collision_dwell_pre", {31'd0, QSEL}, {31'd0, ~q0});
    tick(1);
    chk("collision_dwell_next", {31'd0, QSEL}, {31'd0, q0});
    auto_en = 1'b0;
    btn_sel = 1'b0;
    tick(10);

`ifdef HEXDISP_SWCNT_EN
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("swcnt_reset", {24'd0, sw_cnt}, 32'd0);
    auto_en = 1'b1;
    tick(10);
    chk("swcnt_one", {24'd0, sw_cnt}, 32'd1);
    tick(254 * 10);
    chk("swcnt_255", {24'd0, sw_cnt}, 32'd255);
    tick(10);
    chk("swcnt_wrap", {24'd0, sw_cnt}, 32'd0);
    chk("swcnt_qsel", {31'd0, QSEL}, 32'd0);
    auto_en = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
